// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
//   Produces the stall, enable and clear controls for the pipeline registers.
//   It detects three conditions:
//     - load-use hazards between decode and execute,
//     - taken-branch redirects from execute,
//     - data-memory wait states.
//   It also owns the memory-wait FSM with its timeout, plus two saturating
//   performance counters.
//
// Ports
//   clk, rst_n           clock, synchronous active-low reset
//   dec_rs1/rs2          source registers of the decode instruction
//   dec_uses_rs1/rs2     decode instruction actually reads that source
//   ex_rd, ex_DMRd       destination / is-load of the execute instruction
//   br_taken             branch redirect taken in execute
//   mem_req, mem_ready   MEM-stage data access and its completion
//   pc_en, ifid_en, idex_en, exmem_en   pipeline register load enables
//   ifid_clear           flush IF/ID to a bubble
//   clear_eden_hazard    ID/EX bubble insert (load-use or reset)
//   clear_branchUnit     ID/EX flush caused by a taken branch
//   memwb_bubble         inject a bubble into MEM/WB
//   mem_timeout          sticky: a memory wait was force-released
//   stall_cycles         saturating count of stall cycles
//   flush_count          saturating count of branch flushes
module pipeline_hazard_ctrl #(
  parameter int CNT_W       = 32,
  parameter int MEM_TIMEOUT = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       dec_rs1,
  input  logic [4:0]       dec_rs2,
  input  logic             dec_uses_rs1,
  input  logic             dec_uses_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_DMRd,
  input  logic             br_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_clear,
  output logic             idex_en,
  output logic             clear_eden_hazard,
  output logic             clear_branchUnit,
  output logic             exmem_en,
  output logic             memwb_bubble,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  localparam int WC_W = $clog2(MEM_TIMEOUT);

  localparam logic [0:0] FSM_RUN  = 1'b0;
  localparam logic [0:0] FSM_WAIT = 1'b1;

  logic [0:0]      fsm;
  logic [WC_W-1:0] wait_cnt;

  logic load_use;
  logic force_rel;
  logic mem_stall;
  logic br_act;
  logic lu_act;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  assign load_use  = ex_DMRd && (ex_rd != 5'd0) &&
                     ((dec_uses_rs1 && (dec_rs1 == ex_rd)) ||
                      (dec_uses_rs2 && (dec_rs2 == ex_rd)));

  // The last permitted wait cycle releases the stages even without mem_ready.
  assign force_rel = (fsm == FSM_WAIT) && (wait_cnt == WC_W'(MEM_TIMEOUT - 1));
  assign mem_stall = mem_req && !mem_ready && !force_rel;

  // A frozen pipeline holds br_taken/load_use until release; a branch flushes
  // the decode instruction, so a concurrent load-use is moot.
  assign br_act = br_taken && !mem_stall;
  assign lu_act = load_use && !mem_stall && !br_taken;

  always_comb begin
    pc_en             = 1'b1;
    ifid_en           = 1'b1;
    ifid_clear        = 1'b0;
    idex_en           = 1'b1;
    clear_eden_hazard = 1'b0;
    clear_branchUnit  = 1'b0;
    exmem_en          = 1'b1;
    memwb_bubble      = 1'b0;
    if (!rst_n) begin
      pc_en             = 1'b0;
      ifid_en           = 1'b0;
      ifid_clear        = 1'b1;
      idex_en           = 1'b0;
      clear_eden_hazard = 1'b1;
      exmem_en          = 1'b0;
      memwb_bubble      = 1'b1;
    end else if (mem_stall) begin
      pc_en        = 1'b0;
      ifid_en      = 1'b0;
      idex_en      = 1'b0;
      exmem_en     = 1'b0;
      memwb_bubble = 1'b1;
    end else if (br_act) begin
      ifid_clear       = 1'b1;
      clear_branchUnit = 1'b1;
    end else if (lu_act) begin
      pc_en             = 1'b0;
      ifid_en           = 1'b0;
      clear_eden_hazard = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fsm          <= FSM_RUN;
      wait_cnt     <= '0;
      mem_timeout  <= 1'b0;
      stall_cycles <= '0;
      flush_count  <= '0;
    end else begin
      case (fsm)
        FSM_RUN: begin
          if (mem_stall) begin
            fsm      <= FSM_WAIT;
            wait_cnt <= WC_W'(1);
          end
        end
        default: begin
          if (mem_stall) begin
            wait_cnt <= wait_cnt + WC_W'(1);
          end else begin
            fsm      <= FSM_RUN;
            wait_cnt <= '0;
          end
        end
      endcase
      if (force_rel) begin
        mem_timeout <= 1'b1;
      end
      if (mem_stall || lu_act) begin
        stall_cycles <= sat_inc(stall_cycles);
      end
      if (br_act) begin
        flush_count <= sat_inc(flush_count);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (CNT_W=3, MEM_TIMEOUT=4).
// The driver applies one input vector per cycle and queues the hand-computed
// expected response; the monitor pops and compares on every falling edge.
// Control vector order: {pc_en, ifid_en, ifid_clear, idex_en,
//                        clear_eden_hazard, clear_branchUnit, exmem_en, memwb_bubble}
module tb_pipeline_hazard_ctrl;

  localparam int CNT_W       = 3;
  localparam int MEM_TIMEOUT = 4;

  localparam logic [7:0] C_NORM = 8'b1101_0010;
  localparam logic [7:0] C_RST  = 8'b0010_1001;
  localparam logic [7:0] C_STL  = 8'b0000_0001;
  localparam logic [7:0] C_BR   = 8'b1111_0110;
  localparam logic [7:0] C_LU   = 8'b0001_1010;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [4:0]       dec_rs1 = '0, dec_rs2 = '0, ex_rd = '0;
  logic             dec_uses_rs1 = 1'b0, dec_uses_rs2 = 1'b0;
  logic             ex_DMRd = 1'b0, br_taken = 1'b0, mem_req = 1'b0, mem_ready = 1'b0;
  logic             pc_en, ifid_en, ifid_clear, idex_en;
  logic             clear_eden_hazard, clear_branchUnit, exmem_en, memwb_bubble;
  logic             mem_timeout;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  typedef struct {
    logic [7:0] ctl;
    int         s;
    int         f;
    logic       to;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)) dut (
    .clk(clk), .rst_n(rst_n),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_uses_rs1(dec_uses_rs1), .dec_uses_rs2(dec_uses_rs2),
    .ex_rd(ex_rd), .ex_DMRd(ex_DMRd), .br_taken(br_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .ifid_clear(ifid_clear), .idex_en(idex_en),
    .clear_eden_hazard(clear_eden_hazard), .clear_branchUnit(clear_branchUnit),
    .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .mem_timeout(mem_timeout),
    .stall_cycles(stall_cycles), .flush_count(flush_count)
  );

  always #5 clk = ~clk;

  // Monitor: every driven cycle presents one response at the falling edge.
  exp_t       m_e;
  string      m_n;
  logic [7:0] m_ctl;
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      m_e   = exp_q.pop_front();
      m_n   = name_q.pop_front();
      m_ctl = {pc_en, ifid_en, ifid_clear, idex_en,
               clear_eden_hazard, clear_branchUnit, exmem_en, memwb_bubble};
      checks++;
      if (m_ctl !== m_e.ctl || int'(stall_cycles) != m_e.s ||
          int'(flush_count) != m_e.f || mem_timeout !== m_e.to) begin
        errors++;
        $display("FAIL %s: got ctl=%b stall=%0d flush=%0d to=%b, expected ctl=%b stall=%0d flush=%0d to=%b",
                 m_n, m_ctl, stall_cycles, flush_count, mem_timeout,
                 m_e.ctl, m_e.s, m_e.f, m_e.to);
      end
    end
  end

  task automatic cyc(input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
                     input logic u1, input logic u2, input logic [4:0] rd,
                     input logic ld, input logic br, input logic req, input logic rdy,
                     input logic [7:0] ec, input int es, input int ef, input logic eto,
                     input string nm);
    exp_t e;
    @(posedge clk);
    #1;
    rst_n = r;  dec_rs1 = rs1; dec_rs2 = rs2; dec_uses_rs1 = u1; dec_uses_rs2 = u2;
    ex_rd = rd; ex_DMRd = ld;  br_taken = br; mem_req = req;     mem_ready = rdy;
    e.ctl = ec; e.s = es; e.f = ef; e.to = eto;
    exp_q.push_back(e);
    name_q.push_back(nm);
  endtask

  task automatic idle(input logic [7:0] ec, input int es, input int ef, input logic eto,
                      input string nm);
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, ec, es, ef, eto, nm);
  endtask

  task automatic memc(input logic r, input logic rdy, input logic [7:0] ec, input int es,
                      input int ef, input logic eto, input string nm);
    cyc(r, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, rdy, ec, es, ef, eto, nm);
  endtask

  task automatic rst_cyc(input int es, input int ef, input logic eto, input string nm);
    cyc(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, C_RST, es, ef, eto, nm);
  endtask

  initial begin
    // Reset held with random inputs: controls forced, state cleared.
    for (int i = 0; i < 3; i++) begin
      cyc(1'b0, 5'($urandom), 5'($urandom), 1'($urandom), 1'($urandom), 5'($urandom),
          1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), C_RST, 0, 0, 1'b0, "reset_hold");
    end
    idle(C_NORM, 0, 0, 1'b0, "reset_release");

    // Load-use detection
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   0, 0, 1'b0, "lu_rs2");
    idle(C_NORM, 1, 0, 1'b0, "lu_single_bubble");
    cyc(1'b1, 5'd0, 5'd0, 1'b1, 1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 1, 0, 1'b0, "lu_rd_zero");
    cyc(1'b1, 5'd7, 5'd3, 1'b0, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_NORM, 1, 0, 1'b0, "lu_rs1_unused");
    cyc(1'b1, 5'd7, 5'd3, 1'b1, 1'b1, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,   1, 0, 1'b0, "lu_rs1");
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b0, 1'b0, 1'b0, 1'b0, C_NORM, 2, 0, 1'b0, "lu_not_load");
    rst_cyc(2, 0, 1'b0, "rst_a");

    // Branch beats load-use
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 1'b0, C_BR, 0, 0, 1'b0, "br_vs_lu");
    idle(C_NORM, 0, 1, 1'b0, "br_vs_lu_after");
    cyc(1'b1, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b0, C_BR, 0, 1, 1'b0, "br_only");
    idle(C_NORM, 0, 2, 1'b0, "br_only_after");
    rst_cyc(0, 2, 1'b0, "rst_b");

    // Memory wait with branch + load-use held; flush lands on the ready cycle
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_STL, 0, 0, 1'b0, "mw_freeze1");
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b0, C_STL, 1, 0, 1'b0, "mw_freeze2");
    cyc(1'b1, 5'd0, 5'd5, 1'b0, 1'b1, 5'd5, 1'b1, 1'b1, 1'b1, 1'b1, C_BR,  2, 0, 1'b0, "mw_ready_flush");
    idle(C_NORM, 2, 1, 1'b0, "mw_after");
    memc(1'b1, 1'b1, C_NORM, 2, 1, 1'b0, "zero_wait");
    memc(1'b1, 1'b0, C_STL,  2, 1, 1'b0, "mw_fresh");
    memc(1'b1, 1'b1, C_NORM, 3, 1, 1'b0, "mw_fresh_ready");
    rst_cyc(3, 1, 1'b0, "rst_c");

    // Timeout: three frozen cycles then forced release, flag sticks
    memc(1'b1, 1'b0, C_STL,  0, 0, 1'b0, "to_freeze1");
    memc(1'b1, 1'b0, C_STL,  1, 0, 1'b0, "to_freeze2");
    memc(1'b1, 1'b0, C_STL,  2, 0, 1'b0, "to_freeze3");
    memc(1'b1, 1'b0, C_NORM, 3, 0, 1'b0, "to_force_release");
    idle(C_NORM, 3, 0, 1'b1, "to_flag_set");
    memc(1'b1, 1'b1, C_NORM, 3, 0, 1'b1, "to_flag_sticky");
    idle(C_NORM, 3, 0, 1'b1, "to_flag_hold");
    rst_cyc(3, 0, 1'b1, "rst_d");

    // Saturation: ten load-use cycles on a 3-bit counter
    for (int k = 0; k < 10; k++) begin
      cyc(1'b1, 5'd9, 5'd0, 1'b1, 1'b0, 5'd9, 1'b1, 1'b0, 1'b0, 1'b0, C_LU,
          (k < 7) ? k : 7, 0, 1'b0, "sat_lu");
    end
    idle(C_NORM, 7, 0, 1'b0, "sat_hold");

    // Reset in the middle of a wait abandons it without a timeout
    memc(1'b1, 1'b0, C_STL,  7, 0, 1'b0, "mwr_freeze1");
    memc(1'b1, 1'b0, C_STL,  7, 0, 1'b0, "mwr_freeze2");
    memc(1'b0, 1'b0, C_RST,  7, 0, 1'b0, "mwr_reset");
    memc(1'b1, 1'b0, C_STL,  0, 0, 1'b0, "mwr_restart1");
    memc(1'b1, 1'b0, C_STL,  1, 0, 1'b0, "mwr_restart2");
    memc(1'b1, 1'b0, C_STL,  2, 0, 1'b0, "mwr_restart3");
    memc(1'b1, 1'b0, C_NORM, 3, 0, 1'b0, "mwr_force");
    idle(C_NORM, 3, 0, 1'b1, "mwr_flag");

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    #1;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
